pc_gen: RTL and testbench

Parametrised fetch-address generator for the pipelined MIPS core, superseding the single-register PC. It holds the current fetch PC and selects the next one from, in priority order, exception vector, exception return, execute-stage redirect, stall hold, return-address-stack prediction, or sequential PC+4. It owns the EPC register and a small circular return-address stack (RAS) fed by decode. Output `pc` drives the instruction memory and the IF/ID register.

---
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, the EPC and a circular
// return-address stack, and picks the next PC by fixed event priority.
module pc_gen #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0C00,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         exc,
  input  logic                         eret,
  input  logic                         ras_push,
  input  logic [WIDTH-1:0]             ras_push_addr,
  input  logic                         pred_ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         addr_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(32'd4);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top;

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] epc_next;
  logic [PW-1:0]    top_next;
  logic [CW-1:0]    count_next;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;

  // Next-state selection; exc/eret/redirect/stall squash all RAS activity.
  always_comb begin
    pc_next    = pc;
    epc_next   = epc;
    top_next   = top;
    count_next = ras_count;
    wr_en      = 1'b0;
    wr_idx     = top;
    if (exc) begin
      pc_next  = EXC_VECTOR;
      epc_next = pc;
    end else if (eret) begin
      pc_next = epc;
    end else if (redirect) begin
      pc_next = redirect_pc;
    end else if (stall) begin
      pc_next = pc;
    end else if (pred_ret && !ras_empty) begin
      pc_next = ras_mem[top];
      if (ras_push) begin
        // Simultaneous call/return: replace the top in place.
        wr_en = 1'b1;
      end else begin
        top_next   = top - PTR_ONE;
        count_next = ras_count - CNT_ONE;
      end
    end else begin
      pc_next = pc + PC_STEP;
      if (ras_push) begin
        wr_en      = 1'b1;
        wr_idx     = top + PTR_ONE;
        top_next   = top + PTR_ONE;
        count_next = ras_full ? ras_count : ras_count + CNT_ONE;
      end else begin
        top_next = top;
      end
    end
  end

  // Architectural state and registered RAS status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      epc       <= {WIDTH{1'b0}};
      top       <= {PW{1'b0}};
      ras_count <= {CW{1'b0}};
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
    end else begin
      pc        <= pc_next;
      epc       <= epc_next;
      top       <= top_next;
      ras_count <= count_next;
      ras_empty <= (count_next == {CW{1'b0}});
      ras_full  <= (count_next == CNT_MAX);
    end
  end

  // RAS storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_idx] <= ras_push_addr;
    end
  end

  assign addr_err = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, a mid-cycle reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0, exc = 1'b0, eret = 1'b0;
  logic        ras_push = 1'b0, pred_ret = 1'b0;
  logic [31:0] redirect_pc = 32'h0, ras_push_addr = 32'h0;
  logic [31:0] pc, epc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, addr_err;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc(exc), .eret(eret),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .pred_ret(pred_ret),
    .pc(pc), .epc(epc), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, redirect;
    logic [31:0] rpc;
    logic        exc, eret, push;
    logic [31:0] paddr;
    logic        pred;
    logic [31:0] e_pc, e_epc;
    int          e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc, input int e_cnt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".epc"}, epc, e_epc);
    chk({tag, ".ras_count"}, {29'd0, ras_count}, e_cnt);
    chk({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, e_cnt == 0});
    chk({tag, ".ras_full"}, {31'd0, ras_full}, {31'd0, e_cnt == 4});
    chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e_pc[1:0] != 2'b00});
  endtask

  task automatic model_reset();
    m_pc  = 32'h0000_0C00;
    m_epc = 32'h0;
    m_ras.delete();
  endtask

  // Reference rules: priority list, RAS as a bounded stack of return addresses.
  task automatic model_step(input logic s, rd, input logic [31:0] rpc,
                            input logic ex, er, pu, input logic [31:0] pa, input logic pr);
    if (ex) begin
      m_epc = m_pc;
      m_pc  = 32'h0000_4180;
    end else if (er) begin
      m_pc = m_epc;
    end else if (rd) begin
      m_pc = rpc;
    end else if (s) begin
      m_pc = m_pc;
    end else if (pr && m_ras.size() > 0) begin
      m_pc = m_ras[m_ras.size()-1];
      if (pu) m_ras[m_ras.size()-1] = pa;
      else void'(m_ras.pop_back());
    end else begin
      m_pc = m_pc + 32'd4;
      if (pu) begin
        if (m_ras.size() == 4) void'(m_ras.pop_front());
        m_ras.push_back(pa);
      end
    end
  endtask

  task automatic step(input logic s, rd, input logic [31:0] rpc,
                      input logic ex, er, pu, input logic [31:0] pa, input logic pr);
    stall = s; redirect = rd; redirect_pc = rpc; exc = ex; eret = er;
    ras_push = pu; ras_push_addr = pa; pred_ret = pr;
    @(posedge clk);
    model_step(s, rd, rpc, ex, er, pu, pa, pr);
    #1;
  endtask

  vec_t vecs[$];

  task automatic add(input logic s, rd, input logic [31:0] rpc, input logic ex, er, pu,
                     input logic [31:0] pa, input logic pr,
                     input logic [31:0] e_pc, e_epc, input int e_cnt);
    vec_t v;
    v.stall = s; v.redirect = rd; v.rpc = rpc; v.exc = ex; v.eret = er;
    v.push = pu; v.paddr = pa; v.pred = pr;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    //   stall rd rpc            exc eret push paddr         pred  e_pc           e_epc          cnt
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_0C04, 32'h0,         0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_0C08, 32'h0,         0);
    add(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h111,   1'b0, 32'h0000_0C08, 32'h0,         0);
    add(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h222,   1'b1, 32'h0000_0C08, 32'h0,         0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_0C0C, 32'h0,         0);
    add(1'b1, 1'b1, 32'h2000,   1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_2000, 32'h0,         0);
    add(1'b0, 1'b1, 32'h5000,   1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_4180, 32'h2000,      0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0000_2000, 32'h2000,      0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h100,   1'b0, 32'h0000_2004, 32'h2000,      1);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h200,   1'b0, 32'h0000_2008, 32'h2000,      2);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h300,   1'b0, 32'h0000_200C, 32'h2000,      3);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h400,   1'b0, 32'h0000_2010, 32'h2000,      4);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h500,   1'b0, 32'h0000_2014, 32'h2000,      4);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0500, 32'h2000,      3);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0400, 32'h2000,      2);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0300, 32'h2000,      1);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0200, 32'h2000,      0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0204, 32'h2000,      0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h300,   1'b0, 32'h0000_0208, 32'h2000,      1);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h700,   1'b1, 32'h0000_0300, 32'h2000,      1);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0700, 32'h2000,      0);
    add(1'b0, 1'b1, 32'h2002,   1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_2002, 32'h2000,      0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_2006, 32'h2000,      0);
    add(1'b0, 1'b1, 32'h3000,   1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0000_3000, 32'h2000,      0);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h900,   1'b1, 32'h0000_3004, 32'h2000,      1);
    add(1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 32'hABC,   1'b1, 32'h0000_4180, 32'h3004,      1);
    add(1'b0, 1'b1, 32'h40,     1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0040, 32'h3004,      1);
    add(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0040, 32'h3004,      1);
    add(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 32'h0000_0900, 32'h3004,      0);

    // Reset state, then release away from the clock edge.
    model_reset();
    #12;
    chk_all("reset", 32'h0000_0C00, 32'h0, 0);
    rst = 1'b0;
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].exc, vecs[i].eret,
           vecs[i].push, vecs[i].paddr, vecs[i].pred);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_epc, vecs[i].e_cnt);
    end

    // Mid-cycle reset while stall/redirect/push are active.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h5550;
    ras_push = 1'b1; ras_push_addr = 32'h123;
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst", 32'h0000_0C00, 32'h0, 0);
    @(posedge clk);
    #1;
    chk_all("midrst_hold", 32'h0000_0C00, 32'h0, 0);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_all("post_rst", 32'h0000_0C04, 32'h0, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic s, rd, ex, er, pu, pr;
      logic [31:0] rpc, pa;
      ex  = ($urandom_range(0, 15) == 0);
      er  = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 4) == 0);
      pu  = ($urandom_range(0, 2) == 0);
      pr  = ($urandom_range(0, 2) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      pa  = $urandom & 32'hFFFF_FFFC;
      step(s, rd, rpc, ex, er, pu, pa, pr);
      chk_all($sformatf("rand%0d", n), m_pc, m_epc, m_ras.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
